acc_cpu_core: RTL and testbench
===============================

# acc_cpu_core

Parametrised multi-cycle accumulator CPU core, the next generation of our 8-bit accumulator machine. It keeps the eight-instruction set and the single-accumulator datapath. Width and address space are now generic. The old combinational memory is replaced by a request/ready memory port that tolerates any number of wait states, and the core exposes halt/resume and debug state. It sits between a top-level wrapper and a single shared instruction/data memory.

## Interface
- DATA_W, 8: data word, accumulator and instruction width.
- ADDR_W, 5: memory address and PC width. Requires ADDR_W <= DATA_W-3; elaboration fails otherwise.
- RESET_PC, 0: PC value loaded by reset.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- go  in  1  resume pulse; only honoured in HALT.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data (accumulator).
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1 for a read.
- mem_ready  in  1  completes the current transaction in the cycle it is sampled high with mem_req=1.
- halted  out  1  core in HALT.
- zero  out  1  accumulator == 0.
- pc_out  out  ADDR_W  current PC (debug).
- acc_out  out  DATA_W  current accumulator (debug).

## Operation
- Instruction word: opcode = IR[DATA_W-1 -: 3], operand address = IR[ADDR_W-1:0]. Bits between these two fields are ignored.
- Opcodes:
  - 0 HLT
  - 1 SKZ: skip next instruction if acc==0.
  - 2 ADD: acc += M.
  - 3 AND: acc &= M.
  - 4 XOR: acc ^= M.
  - 5 LDA: acc = M.
  - 6 STO: M = acc.
  - 7 JMP: PC = operand.
- ADD wraps modulo 2^DATA_W; no carry is kept. PC increments wrap modulo 2^ADDR_W.
- States: FETCH, DECODE, MEM, HALT.
  - FETCH: read at PC. On ready: IR <= rdata, PC <= PC+1, go to DECODE.
  - DECODE, by opcode:
    - HLT: go to HALT.
    - SKZ: if zero then PC <= PC+1; go to FETCH.
    - JMP: PC <= operand; go to FETCH.
    - ADD/AND/XOR/LDA/STO: go to MEM.
  - MEM: request at operand address; mem_we=1 only for STO.
    - On ready: ALU ops and LDA load acc from f(acc, rdata); STO writes acc.
    - Then go to FETCH.
  - HALT: halted=1, no request. When go=1, go to FETCH with PC unchanged (the instruction after HLT).
- mem_req, mem_we and mem_addr are decoded from state and IR. They are stable for the whole transaction. mem_req=1 in every FETCH and MEM cycle.
- go outside HALT is ignored.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, IR=0, acc=0, halted=0, zero=1. While rst=1, mem_req is forced to 0.
- The first fetch request appears in the first cycle after rst falls.
- Zero wait states (ready tied high):
  - ALU/LDA/STO instruction: 3 cycles.
  - SKZ and JMP: 2 cycles.
  - HLT: 2 cycles to halted=1.
- Each wait state (mem_ready=0 while mem_req=1) adds exactly one cycle to FETCH or MEM. No register changes during a wait state.
- Back-to-back transactions are allowed. MEM completion is followed by a FETCH request in the next cycle.
- Reset mid-transaction aborts it: no acc/PC/IR update and no second write pulse. A mem_ready arriving in the reset cycle is ignored.
- An STO and its next fetch are distinct transactions. The write is complete before the following read is issued.
- go and HALT entry can never coincide, because halted only rises after DECODE.
- zero is combinational from acc. SKZ uses acc as it stands at DECODE.

## Structure
- Package acc_cpu_pkg holds:
  - opcode constants (OP_HLT..OP_JMP, 3-bit);
  - the state enum (FETCH, DECODE, MEM, HALT);
  - an opcode field-extraction function parametrised on DATA_W.
- Sub-module acc_cpu_alu: combinational, DATA_W parameter; inputs opcode, acc and mem data; output result. Non-ALU opcodes pass acc through.
- The core holds the FSM, PC, IR and acc registers, plus the memory-port decode.

## Test plan
- Zero-wait program LDA 10, ADD 11, STO 12, HLT with M[10]=8'h05, M[11]=8'h03 -> M[12]=8'h08; halted rises 11 cycles after reset release; pc_out=4.
- Same program with mem_ready low for 2 cycles on every transaction -> identical results; every transaction stretches by exactly 2 cycles; addr/we/wdata stable while waiting.
- SKZ with acc=0 -> next instruction skipped. SKZ with acc=8'h01 -> not skipped. JMP to 5'h1F, then the PC increment wraps to 0.
- ADD wrap: acc=8'hFF + M=8'h02 -> acc=8'h01 and zero=0. XOR of acc with itself -> acc=0 and zero=1.
- HLT, wait 10 cycles with go=0 -> no mem_req. Pulse go -> fetch from the address after HLT. A go pulse during normal execution has no effect.
- Assert rst during a stalled STO MEM cycle -> mem_req=0 next cycle, memory unchanged, all outputs at reset values. DATA_W=16/ADDR_W=8 rerun of the first test gives matching results.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
//   - OP_HLT..OP_JMP : 3-bit opcode constants
//   - state_t        : control FSM states
//   - opcode_of()    : extracts the opcode field from an instruction word of
//                      any width up to IR_MAX_W-1 bits
package acc_cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        MEM    = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Instruction words are zero-extended to this width before extraction so
    // one function serves every DATA_W; a 7-bit index addresses all bits.
    localparam int IR_MAX_W = 128;

    function automatic logic [2:0] opcode_of(input logic [IR_MAX_W-1:0] ir,
                                             input logic [6:0]          data_w);
        return ir[data_w - 7'd1 -: 3];
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Request/ready memory port between the core and the shared memory.
//   mem_req/mem_we/mem_addr/mem_wdata : driven by the core (master)
//   mem_rdata/mem_ready               : driven by the memory (slave)
// A transaction completes in the cycle mem_ready is sampled high with mem_req=1.
interface acc_cpu_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU.
//   opcode_i : instruction opcode
//   acc_i    : current accumulator
//   mdata_i  : memory read data
//   result_o : new accumulator value; non-ALU opcodes (incl. STO) pass acc_i
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        opcode_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] mdata_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = acc_i;
        case (opcode_i)
            OP_ADD:  result_o = acc_i + mdata_i;   // wraps, carry discarded
            OP_AND:  result_o = acc_i & mdata_i;
            OP_XOR:  result_o = acc_i ^ mdata_i;
            OP_LDA:  result_o = mdata_i;
            default: result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with a request/ready memory port.
//   clk, rst : clock, synchronous active-high reset
//   go       : resume pulse, honoured only in HALT
//   mem      : memory master port (acc_cpu_if.master)
//   halted   : core is in HALT
//   zero     : accumulator == 0
//   pc_out   : current PC (debug)
//   acc_out  : current accumulator (debug)
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    acc_cpu_if.master         mem,
    output logic              halted,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out
);

    if (ADDR_W > DATA_W - 3 || DATA_W > IR_MAX_W - 1) begin : g_param_check
        $error("acc_cpu_core: ADDR_W must not exceed DATA_W-3");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;
    logic              req_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;

    assign opcode  = opcode_of(IR_MAX_W'(ir_q), 7'(DATA_W));
    assign operand = ir_q[ADDR_W-1:0];

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode_i (opcode),
        .acc_i    (acc_q),
        .mdata_i  (mem.mem_rdata),
        .result_o (alu_result)
    );

    // Every register holds during a wait state because updates are gated by
    // mem_ready; request, address and direction depend only on state and IR,
    // so they stay stable for the whole transaction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = pc_q;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_HLT: state_d = HALT;
                    OP_SKZ: begin
                        if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = FETCH;
                    end
                    default: state_d = MEM;
                endcase
            end
            MEM: begin
                req_c  = 1'b1;
                addr_c = operand;
                we_c   = (opcode == OP_STO);
                if (mem.mem_ready) begin
                    acc_d   = alu_result;   // STO passes acc through unchanged
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (go) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    // Request is masked during reset so an aborted transaction cannot pulse again.
    assign mem.mem_req   = req_c & ~rst;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = acc_q;

    assign halted  = (state_q == HALT);
    assign zero    = (acc_q == '0);
    assign pc_out  = pc_q;
    assign acc_out = acc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;
    import acc_cpu_pkg::*;

    localparam int DW = 8, AW = 5, DW2 = 16, AW2 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic          halted, zero;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] acc_out;

    acc_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .go(go), .mem(mif.master),
        .halted(halted), .zero(zero), .pc_out(pc_out), .acc_out(acc_out)
    );

    // Wide instance
    logic           rst2 = 1'b1;
    logic           go2  = 1'b0;
    logic           halted2, zero2;
    logic [AW2-1:0] pc2;
    logic [DW2-1:0] acc2;

    acc_cpu_if #(.DATA_W(DW2), .ADDR_W(AW2)) mif2 ();

    acc_cpu_core #(.DATA_W(DW2), .ADDR_W(AW2), .RESET_PC(0)) dut2 (
        .clk(clk), .rst(rst2), .go(go2), .mem(mif2.master),
        .halted(halted2), .zero(zero2), .pc_out(pc2), .acc_out(acc2)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- memory model + scoreboard capture ----------------
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    wr_t wr_q[$];
    wr_t exp_q[$];
    int  wait_n = 0;
    int  wcnt   = 0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_a  = '0;
    logic [DW-1:0] ld_d  = '0;
    int            unstable = 0;
    logic          in_wait  = 1'b0;
    logic [AW-1:0] p_addr, p_pc;
    logic          p_we;
    logic [DW-1:0] p_wdata, p_acc;

    assign mif.mem_rdata = mem[mif.mem_addr];
    assign mif.mem_ready = (wcnt >= wait_n);

    always @(posedge clk) begin
        if (ld_en) mem[ld_a] <= ld_d;
        else if (!rst && mif.mem_req && mif.mem_ready && mif.mem_we) begin
            mem[mif.mem_addr] <= mif.mem_wdata;
            wr_q.push_back(wr_t'{mif.mem_addr, mif.mem_wdata});
        end
        if (rst || !mif.mem_req || mif.mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!rst && mif.mem_req) begin
            if (in_wait && (mif.mem_addr !== p_addr || mif.mem_we !== p_we ||
                            mif.mem_wdata !== p_wdata || pc_out !== p_pc || acc_out !== p_acc))
                unstable <= unstable + 1;
            in_wait <= !mif.mem_ready;
        end else begin
            in_wait <= 1'b0;
        end
        p_addr  <= mif.mem_addr;
        p_we    <= mif.mem_we;
        p_wdata <= mif.mem_wdata;
        p_pc    <= pc_out;
        p_acc   <= acc_out;
    end

    logic [DW2-1:0] mem2 [0:(1<<AW2)-1];
    logic           ld2_en = 1'b0;
    logic [AW2-1:0] ld2_a  = '0;
    logic [DW2-1:0] ld2_d  = '0;
    int             wr2_cnt = 0;

    assign mif2.mem_rdata = mem2[mif2.mem_addr];
    assign mif2.mem_ready = 1'b1;

    always @(posedge clk) begin
        if (ld2_en) mem2[ld2_a] <= ld2_d;
        else if (!rst2 && mif2.mem_req && mif2.mem_ready && mif2.mem_we) begin
            mem2[mif2.mem_addr] <= mif2.mem_wdata;
            wr2_cnt <= wr2_cnt + 1;
        end
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_a = a; ld_d = d; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Enter reset, clear memory and scoreboard.
    task automatic prep(input int waits);
        @(negedge clk);
        rst = 1'b1; go = 1'b0; wait_n = waits;
        for (int i = 0; i < (1<<AW); i++) poke(AW'(i), '0);
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mif.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mif.mem_req); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
        total++; if (pc_out !== 5'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        total++; if (acc_out !== 8'd0) begin bad++; $display("FAIL reset_acc got=%h exp=0", acc_out); end
    endtask

    task automatic basic_prog(input int waits, input int exp_cyc, input string nm);
        int cyc;
        wr_t w, e;
        int  u0;
        prep(waits);
        poke(0, ins(OP_LDA, 10)); poke(1, ins(OP_ADD, 11));
        poke(2, ins(OP_STO, 12)); poke(3, ins(OP_HLT, 0));
        poke(10, 8'h05); poke(11, 8'h03);
        exp_q.push_back(wr_t'{5'd12, 8'h08});
        u0 = unstable;
        rst = 1'b0;
        run_halt(cyc);
        total++; if (cyc != exp_cyc) begin bad++; $display("FAIL %s_cycles got=%0d exp=%0d", nm, cyc, exp_cyc); end
        total++; if (pc_out !== 5'd4) begin bad++; $display("FAIL %s_pc got=%h exp=4", nm, pc_out); end
        total++; if (acc_out !== 8'h08) begin bad++; $display("FAIL %s_acc got=%h exp=08", nm, acc_out); end
        total++; if (mem[12] !== 8'h08) begin bad++; $display("FAIL %s_mem12 got=%h exp=08", nm, mem[12]); end
        total++; if (unstable != u0) begin bad++; $display("FAIL %s_stable got=%0d exp=%0d", nm, unstable, u0); end
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL %s_nwr got=%0d exp=%0d", nm, wr_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            w = wr_q.pop_front(); e = exp_q.pop_front(); total++;
            if (w !== e) begin bad++; $display("FAIL %s_wr got=%h/%h exp=%h/%h", nm, w.a, w.d, e.a, e.d); end
        end
    endtask

    task automatic test_basic();
        basic_prog(0, 11, "basic");
    endtask

    task automatic test_wait_states();
        // 7 transactions, each stretched by 2 cycles
        basic_prog(2, 25, "wait");
    endtask

    task automatic test_skz();
        int cyc;
        wr_t w, e;
        for (int v = 0; v < 2; v++) begin
            prep(0);
            poke(0, ins(OP_LDA, 20)); poke(1, ins(OP_SKZ, 0));
            poke(2, ins(OP_STO, 21)); poke(3, ins(OP_STO, 22)); poke(4, ins(OP_HLT, 0));
            poke(20, DW'(v));
            if (v == 1) exp_q.push_back(wr_t'{5'd21, 8'h01});
            exp_q.push_back(wr_t'{5'd22, DW'(v)});
            rst = 1'b0;
            run_halt(cyc);
            total++; if (cyc != (v == 0 ? 10 : 13)) begin bad++; $display("FAIL skz%0d_cycles got=%0d exp=%0d", v, cyc, (v == 0 ? 10 : 13)); end
            total++; if (pc_out !== 5'd5) begin bad++; $display("FAIL skz%0d_pc got=%h exp=5", v, pc_out); end
            total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL skz%0d_nwr got=%0d exp=%0d", v, wr_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && wr_q.size() > 0) begin
                w = wr_q.pop_front(); e = exp_q.pop_front(); total++;
                if (w !== e) begin bad++; $display("FAIL skz%0d_wr got=%h/%h exp=%h/%h", v, w.a, w.d, e.a, e.d); end
            end
        end
    endtask

    task automatic test_jmp_wrap();
        int cyc;
        prep(0);
        poke(0, ins(OP_JMP, 5'h1F)); poke(5'h1F, ins(OP_HLT, 0));
        rst = 1'b0;
        run_halt(cyc);
        total++; if (cyc != 4) begin bad++; $display("FAIL jmp_cycles got=%0d exp=4", cyc); end
        total++; if (pc_out !== 5'd0) begin bad++; $display("FAIL jmp_pc_wrap got=%h exp=0", pc_out); end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL jmp_nwr got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_alu();
        int cyc;
        wr_t w, e;
        prep(0);
        poke(0, ins(OP_LDA, 20)); poke(1, ins(OP_ADD, 21)); poke(2, ins(OP_STO, 22));
        poke(3, ins(OP_HLT, 0));  poke(4, ins(OP_XOR, 24)); poke(5, ins(OP_AND, 25));
        poke(6, ins(OP_STO, 26)); poke(7, ins(OP_LDA, 26)); poke(8, ins(OP_XOR, 26));
        poke(9, ins(OP_STO, 27)); poke(10, ins(OP_HLT, 0));
        poke(20, 8'hFF); poke(21, 8'h02); poke(24, 8'h5A); poke(25, 8'h0F);
        exp_q.push_back(wr_t'{5'd22, 8'h01});
        exp_q.push_back(wr_t'{5'd26, 8'h0B});
        exp_q.push_back(wr_t'{5'd27, 8'h00});
        rst = 1'b0;
        run_halt(cyc);
        total++; if (cyc != 11) begin bad++; $display("FAIL alu_add_cycles got=%0d exp=11", cyc); end
        total++; if (acc_out !== 8'h01) begin bad++; $display("FAIL alu_add_wrap got=%h exp=01", acc_out); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL alu_add_zero got=%b exp=0", zero); end
        go = 1'b1; @(negedge clk); go = 1'b0;
        run_halt(cyc);
        total++; if (acc_out !== 8'h00) begin bad++; $display("FAIL alu_xor_self got=%h exp=00", acc_out); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL alu_xor_zero got=%b exp=1", zero); end
        total++; if (pc_out !== 5'd11) begin bad++; $display("FAIL alu_pc got=%h exp=0b", pc_out); end
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL alu_nwr got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            w = wr_q.pop_front(); e = exp_q.pop_front(); total++;
            if (w !== e) begin bad++; $display("FAIL alu_wr got=%h/%h exp=%h/%h", w.a, w.d, e.a, e.d); end
        end
    endtask

    task automatic test_halt_go();
        int cyc, reqs;
        wr_t w, e;
        prep(0);
        poke(0, ins(OP_LDA, 20)); poke(1, ins(OP_HLT, 0));
        poke(2, ins(OP_STO, 21)); poke(3, ins(OP_HLT, 0));
        poke(20, 8'h11);
        exp_q.push_back(wr_t'{5'd21, 8'h11});
        rst = 1'b0;
        run_halt(cyc);
        total++; if (cyc != 5) begin bad++; $display("FAIL halt_cycles got=%0d exp=5", cyc); end
        reqs = 0;
        repeat (10) begin @(negedge clk); if (mif.mem_req) reqs++; end
        total++; if (reqs != 0) begin bad++; $display("FAIL halt_noreq got=%0d exp=0", reqs); end
        total++; if (halted !== 1'b1 || pc_out !== 5'd2) begin bad++; $display("FAIL halt_hold got=%b/%h exp=1/02", halted, pc_out); end
        go = 1'b1; @(negedge clk); go = 1'b0;
        total++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 5'd2 || halted !== 1'b0)
            begin bad++; $display("FAIL go_fetch got=%b/%h/%b exp=1/02/0", mif.mem_req, mif.mem_addr, halted); end
        run_halt(cyc);
        total++; if (pc_out !== 5'd4) begin bad++; $display("FAIL go_pc got=%h exp=4", pc_out); end
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL go_nwr got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            w = wr_q.pop_front(); e = exp_q.pop_front(); total++;
            if (w !== e) begin bad++; $display("FAIL go_wr got=%h/%h exp=%h/%h", w.a, w.d, e.a, e.d); end
        end
    endtask

    task automatic test_go_ignored();
        int cyc;
        prep(0);
        poke(0, ins(OP_LDA, 10)); poke(1, ins(OP_ADD, 11));
        poke(2, ins(OP_STO, 12)); poke(3, ins(OP_HLT, 0));
        poke(10, 8'h05); poke(11, 8'h03);
        rst = 1'b0;
        cyc = 0;
        while (!halted && cyc < 400) begin
            go = (cyc < 9);
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        total++; if (cyc != 11) begin bad++; $display("FAIL goign_cycles got=%0d exp=11", cyc); end
        total++; if (mem[12] !== 8'h08) begin bad++; $display("FAIL goign_mem12 got=%h exp=08", mem[12]); end
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL goign_nwr got=%0d exp=1", wr_q.size()); end
    endtask

    task automatic test_reset_abort();
        bit found;
        prep(0);
        poke(0, ins(OP_LDA, 20)); poke(1, ins(OP_STO, 21)); poke(2, ins(OP_HLT, 0));
        poke(20, 8'h77); poke(21, 8'hAA);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mif.mem_req && mif.mem_we) begin wait_n = 100; found = 1'b1; end
        end
        total++; if (!found) begin bad++; $display("FAIL abort_sto_seen got=0 exp=1"); end
        repeat (2) @(negedge clk);
        total++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || acc_out !== 8'h77)
            begin bad++; $display("FAIL abort_stall got=%b/%b/%h exp=1/1/77", mif.mem_req, mif.mem_we, acc_out); end
        rst = 1'b1; wait_n = 0;   // ready arrives in the reset cycle
        @(negedge clk);
        total++; if (mif.mem_req !== 1'b0) begin bad++; $display("FAIL abort_req got=%b exp=0", mif.mem_req); end
        total++; if (pc_out !== 5'd0 || acc_out !== 8'd0) begin bad++; $display("FAIL abort_regs got=%h/%h exp=00/00", pc_out, acc_out); end
        total++; if (halted !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL abort_flags got=%b/%b exp=0/1", halted, zero); end
        total++; if (mem[21] !== 8'hAA) begin bad++; $display("FAIL abort_mem21 got=%h exp=aa", mem[21]); end
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL abort_nwr got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_wide();
        int cyc;
        @(negedge clk);
        rst2 = 1'b1;
        ld2_en = 1'b1;
        ld2_a = 8'd0;  ld2_d = {OP_LDA, 5'b0, 8'd10}; @(negedge clk);
        ld2_a = 8'd1;  ld2_d = {OP_ADD, 5'b0, 8'd11}; @(negedge clk);
        ld2_a = 8'd2;  ld2_d = {OP_STO, 5'b0, 8'd12}; @(negedge clk);
        ld2_a = 8'd3;  ld2_d = {OP_HLT, 13'b0};       @(negedge clk);
        ld2_a = 8'd10; ld2_d = 16'h8005;              @(negedge clk);
        ld2_a = 8'd11; ld2_d = 16'h0003;              @(negedge clk);
        ld2_a = 8'd12; ld2_d = 16'h0000;              @(negedge clk);
        ld2_en = 1'b0;
        rst2 = 1'b0;
        cyc = 0;
        while (!halted2 && cyc < 400) begin @(negedge clk); cyc++; end
        total++; if (cyc != 11) begin bad++; $display("FAIL wide_cycles got=%0d exp=11", cyc); end
        total++; if (pc2 !== 8'd4) begin bad++; $display("FAIL wide_pc got=%h exp=04", pc2); end
        total++; if (acc2 !== 16'h8008) begin bad++; $display("FAIL wide_acc got=%h exp=8008", acc2); end
        total++; if (mem2[12] !== 16'h8008) begin bad++; $display("FAIL wide_mem12 got=%h exp=8008", mem2[12]); end
        total++; if (wr2_cnt != 1) begin bad++; $display("FAIL wide_nwr got=%0d exp=1", wr2_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_skz();
        test_jmp_wrap();
        test_alu();
        test_halt_go();
        test_go_ignored();
        test_reset_abort();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
